// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  // Default number of MEM_WAIT cycles before the access is abandoned
  localparam int TIMEOUT_DEFAULT = 255;

  // Control word injected into ID/EX when a bubble is selected
  localparam logic [6:0] CTRL_NOP = 7'b000_0000;

  // True when the load in ID/EX writes a register that the ID instruction reads.
  // x0 is never a real dependency.
  function automatic logic load_use_hit(
    input logic       mem_read,
    input logic [4:0] rd,
    input logic [4:0] rs1,
    input logic [4:0] rs2,
    input logic       uses_rs1,
    input logic       uses_rs2
  );
    return mem_read && (rd != 5'd0) &&
           ((uses_rs1 && (rs1 == rd)) || (uses_rs2 && (rs2 == rd)));
  endfunction

endpackage

// File: rtl/hazard_wait_timer.sv
// MEM_WAIT watchdog. Implemented as a down-counter: start loads the number of
// further wait cycles allowed, expire_o is the terminal count. Expiry lands on
// the TIMEOUT-th cycle spent waiting.
module hazard_wait_timer
  import hazard_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic start_i,
  input  logic clear_i,
  input  logic tick_i,
  output logic expire_o
);

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] START_VAL = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] remain_q;
  logic [CNT_W-1:0] remain_d;

  // Next remaining-cycle count: clear beats start beats decrement
  always_comb begin
    remain_d = remain_q;
    if (clear_i) begin
      remain_d = '0;
    end else if (start_i) begin
      remain_d = START_VAL;
    end else if (tick_i && (remain_q != '0)) begin
      remain_d = remain_q - 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      remain_q <= '0;
    end else begin
      remain_q <= remain_d;
    end
  end

  assign expire_o = (remain_q == '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Stall / flush / freeze controller around the ID/EX register.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// RUN      | normal issue; handles load-use bubble and taken-branch flush
// MEM_WAIT | data access outstanding; whole pipeline frozen until ack or
//          | watchdog expiry
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic       id_uses_rs1_i,
  input  logic       id_uses_rs2_i,
  input  logic       ex_mem_read_i,
  input  logic [4:0] ex_rd_i,
  input  logic       branch_taken_i,
  input  logic       dmem_req_i,
  input  logic       dmem_ack_i,
  output logic       pc_write_o,
  output logic       if_id_write_o,
  output logic       if_id_flush_o,
  output logic       ctrl_bubble_o,
  output logic       pipe_freeze_o,
  output logic       err_o,
  output logic       state_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
`endif
);

  state_e state_q, state_d;
  logic   err_q, err_d;
  logic   load_use, mem_stall;
  logic   tmr_start, tmr_clear, tmr_tick, tmr_expire;

  assign load_use  = load_use_hit(ex_mem_read_i, ex_rd_i, id_rs1_i, id_rs2_i,
                                  id_uses_rs1_i, id_uses_rs2_i);
  assign mem_stall = dmem_req_i && !dmem_ack_i;

  hazard_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .start_i  (tmr_start),
    .clear_i  (tmr_clear),
    .tick_i   (tmr_tick),
    .expire_o (tmr_expire)
  );

  // Next state, watchdog control and pipeline controls. Reset overrides the
  // controls so the front end holds and ID/EX keeps loading the NOP word.
  always_comb begin
    state_d       = state_q;
    err_d         = err_q;
    tmr_start     = 1'b0;
    tmr_clear     = 1'b0;
    tmr_tick      = 1'b0;
    pc_write_o    = 1'b1;
    if_id_write_o = 1'b1;
    if_id_flush_o = 1'b0;
    ctrl_bubble_o = 1'b0;
    pipe_freeze_o = 1'b0;

    case (state_q)
      RUN: begin
        if (mem_stall) begin
          pipe_freeze_o = 1'b1;
          pc_write_o    = 1'b0;
          if_id_write_o = 1'b0;
          tmr_start     = 1'b1;
          state_d       = MEM_WAIT;
        end else if (load_use) begin
          // A taken branch here used a stale operand; it re-resolves next cycle
          pc_write_o    = 1'b0;
          if_id_write_o = 1'b0;
          ctrl_bubble_o = 1'b1;
        end else if (branch_taken_i) begin
          if_id_flush_o = 1'b1;
        end
      end
      MEM_WAIT: begin
        pipe_freeze_o = 1'b1;
        pc_write_o    = 1'b0;
        if_id_write_o = 1'b0;
        if (dmem_ack_i) begin
          tmr_clear = 1'b1;
          state_d   = RUN;
        end else if (tmr_expire) begin
          err_d     = 1'b1;
          tmr_clear = 1'b1;
          state_d   = RUN;
        end else begin
          tmr_tick = 1'b1;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase

    if (!rst_n_i) begin
      pc_write_o    = 1'b0;
      if_id_write_o = 1'b0;
      if_id_flush_o = 1'b0;
      ctrl_bubble_o = 1'b1;
      pipe_freeze_o = 1'b0;
    end
  end

  // State and sticky error registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= RUN;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  assign err_o   = err_q;
  assign state_o = logic'(state_q);

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Counter increments; the async reset keeps both at zero while rst_n_i is low
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pc_write_o) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (if_id_flush_o) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end

  // Performance counter registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl, built with a short watchdog (TIMEOUT=4).
// Inputs change just after a rising edge; outputs are checked on the falling edge.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       uses_rs1, uses_rs2, mem_read, branch, req, ack;
  logic       pc_write, if_id_write, flush, bubble, freeze, err, state;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.TIMEOUT(4)) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .id_rs1_i       (id_rs1),
    .id_rs2_i       (id_rs2),
    .id_uses_rs1_i  (uses_rs1),
    .id_uses_rs2_i  (uses_rs2),
    .ex_mem_read_i  (mem_read),
    .ex_rd_i        (ex_rd),
    .branch_taken_i (branch),
    .dmem_req_i     (req),
    .dmem_ack_i     (ack),
    .pc_write_o     (pc_write),
    .if_id_write_o  (if_id_write),
    .if_id_flush_o  (flush),
    .ctrl_bubble_o  (bubble),
    .pipe_freeze_o  (freeze),
    .err_o          (err),
    .state_o        (state)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cnt_o    (stall_cnt),
    .flush_cnt_o    (flush_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks the five pipeline controls as {pc_write, if_id_write, flush, bubble, freeze}
  task automatic chk_ctl(input string tag, input logic [4:0] exp);
    chk(tag, {27'd0, pc_write, if_id_write, flush, bubble, freeze}, {27'd0, exp});
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    uses_rs1 = 1'b0; uses_rs2 = 1'b0; mem_read = 1'b0;
    branch = 1'b0; req = 1'b0; ack = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();

    // Reset held
    @(negedge clk);
    chk_ctl("reset_ctl", 5'b00010);
    chk("reset_state", state, 1'b0);
    chk("reset_err", err, 1'b0);
    rst_n = 1'b1;
    next_cycle();

    // Normal issue
    @(negedge clk);
    chk_ctl("idle_ctl", 5'b11000);
    next_cycle();

    // lw x5 in ID/EX, add reads rs1=x5 -> one bubble
    mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; uses_rs1 = 1'b1;
    @(negedge clk);
    chk_ctl("lu_rs1_ctl", 5'b00010);
    next_cycle();
    mem_read = 1'b0;
    @(negedge clk);
    chk_ctl("lu_after_ctl", 5'b11000);
    next_cycle();

    // rs2 dependency, and the same match with uses_rs2 clear
    uses_rs1 = 1'b0; id_rs1 = 5'd3; uses_rs2 = 1'b1; id_rs2 = 5'd7;
    ex_rd = 5'd7; mem_read = 1'b1;
    @(negedge clk);
    chk_ctl("lu_rs2_ctl", 5'b00010);
    next_cycle();
    uses_rs2 = 1'b0;
    @(negedge clk);
    chk_ctl("lu_rs2_unused_ctl", 5'b11000);
    next_cycle();

    // rd=x0 is never a hazard
    ex_rd = 5'd0; id_rs1 = 5'd0; uses_rs1 = 1'b1;
    @(negedge clk);
    chk_ctl("lu_x0_ctl", 5'b11000);
    next_cycle();

    // Load-use beats branch; branch flushes next cycle
    ex_rd = 5'd9; id_rs1 = 5'd9; branch = 1'b1;
    @(negedge clk);
    chk_ctl("lu_branch_ctl", 5'b00010);
    next_cycle();
    mem_read = 1'b0;
    @(negedge clk);
    chk_ctl("branch_ctl", 5'b11100);
    next_cycle();
    idle_inputs();

    // Access acked on the third wait cycle: 4 frozen cycles, 3 in MEM_WAIT
    req = 1'b1;
    @(negedge clk);
    chk_ctl("mw0_ctl", 5'b00001);
    chk("mw0_state", state, 1'b0);
    next_cycle();
    branch = 1'b1; mem_read = 1'b1; ex_rd = 5'd4; id_rs1 = 5'd4; uses_rs1 = 1'b1;
    @(negedge clk);
    chk_ctl("mw1_ctl", 5'b00001);
    chk("mw1_state", state, 1'b1);
    next_cycle();
    idle_inputs();
    req = 1'b1;
    @(negedge clk);
    chk_ctl("mw2_ctl", 5'b00001);
    chk("mw2_state", state, 1'b1);
    next_cycle();
    ack = 1'b1;
    @(negedge clk);
    chk_ctl("mw3_ack_ctl", 5'b00001);
    chk("mw3_state", state, 1'b1);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    chk_ctl("mw_done_ctl", 5'b11000);
    chk("mw_done_state", state, 1'b0);
    chk("mw_done_err", err, 1'b0);
    next_cycle();

    // Request acked in the same cycle: no stall
    req = 1'b1; ack = 1'b1;
    @(negedge clk);
    chk_ctl("req_ack_ctl", 5'b11000);
    next_cycle();
    @(negedge clk);
    chk("req_ack_state", state, 1'b0);
    next_cycle();
    idle_inputs();

    // Timeout with TIMEOUT=4: RUN stall cycle then 4 wait cycles
    req = 1'b1;
    next_cycle();
    next_cycle();
    next_cycle();
    next_cycle();
    req = 1'b0;
    @(negedge clk);
    chk("to_last_wait_state", state, 1'b1);
    chk("to_last_wait_err", err, 1'b0);
    next_cycle();
    @(negedge clk);
    chk("to_err", err, 1'b1);
    chk("to_state", state, 1'b0);
    chk_ctl("to_ctl", 5'b11000);
    next_cycle();
    @(negedge clk);
    chk("to_err_sticky", err, 1'b1);

    // Reset in the middle of MEM_WAIT
    next_cycle();
    req = 1'b1;
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("rst_mid_pre_state", state, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_state", state, 1'b0);
    chk("rst_mid_err", err, 1'b0);
    chk_ctl("rst_mid_ctl", 5'b00010);
    req = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    chk_ctl("rst_release_ctl", 5'b11000);
    chk("rst_release_state", state, 1'b0);
    next_cycle();

`ifdef HAZARD_PERF_CNT_EN
    // Fresh counters: two load-use stalls and one flush
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    next_cycle();
    mem_read = 1'b1; ex_rd = 5'd6; id_rs1 = 5'd6; uses_rs1 = 1'b1;
    next_cycle();
    mem_read = 1'b0;
    next_cycle();
    mem_read = 1'b1;
    next_cycle();
    mem_read = 1'b0; branch = 1'b1;
    next_cycle();
    idle_inputs();
    next_cycle();
    @(negedge clk);
    chk("perf_stall_cnt", stall_cnt, 32'd2);
    chk("perf_flush_cnt", flush_cnt, 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
